// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sentinel and halt encoding, fetch state, and
// instruction field positions that the fetch unit and the decoder both use.
package cpu_pkg;

  localparam logic [31:0] SENTINEL_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] HALT_WORD     = 32'hFC00_0000;
  localparam logic [5:0]  OP_HALT       = 6'h3F;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: memory address/data plus the decode-side handshake and tagged word.
// master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if;

  logic [31:0] o_Addr;
  logic [31:0] i_Instruction;
  logic        i_Stall;
  logic        i_Redirect;
  logic [31:0] i_Target;
  logic [31:0] o_Instruction;
  logic [5:0]  o_Opcode;
  logic [5:0]  o_Funct;
  logic [31:0] o_Pc;
  logic [31:0] o_Pc_Plus4;
  logic        o_Valid;
  logic        o_Halted;
  logic        o_Fault;
  logic [31:0] o_Fetch_Count;

  modport master (
    input  i_Instruction, i_Stall, i_Redirect, i_Target,
    output o_Addr, o_Instruction, o_Opcode, o_Funct, o_Pc, o_Pc_Plus4,
           o_Valid, o_Halted, o_Fault, o_Fetch_Count
  );

  modport slave (
    output i_Instruction, i_Stall, i_Redirect, i_Target,
    input  o_Addr, o_Instruction, o_Opcode, o_Funct, o_Pc, o_Pc_Plus4,
           o_Valid, o_Halted, o_Fault, o_Fetch_Count
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for a 1-cycle-latency instruction memory.
// Optional address-bounds check enabled by defining IFU_BOUNDS_CHECK_EN.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  instruction_fetch_unit_if.master  bus
);

  logic [31:0]  r_Pc;
  logic [31:0]  r_Pc_D;
  logic         r_Valid;
  fetch_state_e r_State;
  logic [31:0]  r_Count;

  logic [31:0]  w_Target;
  logic [31:0]  w_Addr_Raw;
  logic [31:0]  w_Instr;
  logic         w_Consume;
  logic         w_Oob;

  assign w_Target  = word_align(bus.i_Target);
  assign w_Consume = r_Valid & (~bus.i_Stall | bus.i_Redirect);
  assign w_Instr   = r_Valid ? bus.i_Instruction : HALT_WORD;

  // Stall replays pc_d so the memory re-reads the held word.
  always_comb begin
    w_Addr_Raw = r_Pc;
    if (bus.i_Redirect)
      w_Addr_Raw = w_Target;
    else if (r_State == FETCH_HALT)
      w_Addr_Raw = SENTINEL_ADDR;
    else if (bus.i_Stall)
      w_Addr_Raw = r_Pc_D;
  end

`ifdef IFU_BOUNDS_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(IMEM_WORDS * 4);
  logic r_Fault;

  assign w_Oob = (w_Addr_Raw != SENTINEL_ADDR) && (w_Addr_Raw >= ADDR_LIMIT) &&
                 (bus.i_Redirect || (r_State == FETCH_RUN));

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      r_Fault <= 1'b0;
    else if (w_Oob)
      r_Fault <= 1'b1;
  end

  assign bus.o_Fault = r_Fault;
`else
  assign w_Oob       = 1'b0;
  assign bus.o_Fault = 1'b0;
`endif

  assign bus.o_Addr = (i_Rst || w_Oob) ? SENTINEL_ADDR : w_Addr_Raw;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Pc    <= RESET_PC;
      r_Pc_D  <= SENTINEL_ADDR;
      r_Valid <= 1'b0;
      r_State <= FETCH_RUN;
      r_Count <= 32'd0;
    end else begin
      if (w_Consume)
        r_Count <= r_Count + 32'd1;

      if (w_Oob) begin
        r_State <= FETCH_HALT;
        r_Valid <= 1'b0;
      end else if (bus.i_Redirect) begin
        r_Pc_D  <= w_Target;
        r_Pc    <= w_Target + 32'd4;
        r_Valid <= 1'b1;
        r_State <= FETCH_RUN;
      end else if (r_State == FETCH_HALT) begin
        r_Valid <= 1'b0;
      end else if (w_Consume && (w_Instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT)) begin
        // The halt word has been delivered once; stop and keep pc.
        r_State <= FETCH_HALT;
        r_Valid <= 1'b0;
      end else if (!bus.i_Stall) begin
        r_Pc_D  <= r_Pc;
        r_Pc    <= r_Pc + 32'd4;
        r_Valid <= 1'b1;
      end
    end
  end

  assign bus.o_Instruction = w_Instr;
  assign bus.o_Opcode      = w_Instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.o_Funct       = w_Instr[FUNCT_MSB:FUNCT_LSB];
  assign bus.o_Pc          = r_Pc_D;
  assign bus.o_Pc_Plus4    = r_Pc_D + 32'd4;
  assign bus.o_Valid       = r_Valid;
  assign bus.o_Halted      = (r_State == FETCH_HALT);
  assign bus.o_Fetch_Count = r_Count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: consumed words are checked
// against a scoreboard of expected {pc, word} pairs; state checks are inline.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (128)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  logic [31:0] mem [0:127];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == SENTINEL_ADDR) return HALT_WORD;
    return mem[a[8:2]];
  endfunction

  // Single-cycle-latency instruction memory
  always @(posedge clk) bus.i_Instruction <= mem_word(bus.o_Addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expected word per consume event
  always @(negedge clk) begin
    if (!rst && bus.o_Valid && (!bus.i_Stall || bus.i_Redirect)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL sb_underflow observed pc=%h expected=none", bus.o_Pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.o_Pc, e.pc);
        chk("sb_instr", bus.o_Instruction, e.instr);
        chk("sb_pc_plus4", bus.o_Pc_Plus4, e.pc + 32'd4);
        $display("consume pc=%h instr=%h count=%0d", bus.o_Pc, bus.o_Instruction, bus.o_Fetch_Count);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + (i << 8) + i;
    mem[4] = HALT_WORD;
    bus.i_Stall    = 1'b0;
    bus.i_Redirect = 1'b0;
    bus.i_Target   = 32'h0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_valid", bus.o_Valid, 1'b0);
    chk("rst_pc", bus.o_Pc, SENTINEL_ADDR);
    chk("rst_instr", bus.o_Instruction, HALT_WORD);
    chk("rst_opcode", 32'(bus.o_Opcode), 32'h3F);
    chk("rst_funct", 32'(bus.o_Funct), 32'h0);
    chk("rst_pc_plus4", bus.o_Pc_Plus4, 32'h0);
    chk("rst_addr", bus.o_Addr, SENTINEL_ADDR);
    chk("rst_count", bus.o_Fetch_Count, 32'd0);
    chk1("rst_halted", bus.o_Halted, 1'b0);
    chk1("rst_fault", bus.o_Fault, 1'b0);

    // Straight-line run into the halt word at 16
    rst = 1'b0;
    push(32'h0);
    #1;
    chk("first_addr", bus.o_Addr, 32'h0);
    chk1("first_valid", bus.o_Valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) push(32'(4 * k + 4));
      chk("run_pc", bus.o_Pc, 32'(4 * k));
      chk1("run_valid", bus.o_Valid, 1'b1);
    end
    tick();
    chk1("halt_halted", bus.o_Halted, 1'b1);
    chk1("halt_valid", bus.o_Valid, 1'b0);
    chk("halt_count", bus.o_Fetch_Count, 32'd5);
    chk("halt_addr", bus.o_Addr, SENTINEL_ADDR);

    // Redirect out of HALT with a misaligned target
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h23;
    push(32'h20);
    #1;
    chk("redir_align_addr", bus.o_Addr, 32'h20);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h24);
    #1;
    chk("resume_pc", bus.o_Pc, 32'h20);
    chk1("resume_halted", bus.o_Halted, 1'b0);
    chk("resume_count", bus.o_Fetch_Count, 32'd5);

    tick();
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h0;
    push(32'h0);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h4);
    chk("redir0_count", bus.o_Fetch_Count, 32'd7);

    // Redirect to 0x40 while o_Pc = 4: no bubble, word 4 counted once
    tick();
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h40;
    push(32'h40);
    #1;
    chk("redir40_pre_count", bus.o_Fetch_Count, 32'd8);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h44);
    chk("redir40_pc", bus.o_Pc, 32'h40);
    chk1("redir40_valid", bus.o_Valid, 1'b1);
    chk("redir40_count", bus.o_Fetch_Count, 32'd9);

    tick();
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h0;
    push(32'h0);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h4);
    chk("back0_count", bus.o_Fetch_Count, 32'd11);
    tick();
    push(32'h8);

    // Stall held 3 cycles at o_Pc = 8
    tick();
    bus.i_Stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      #1;
      chk("stall_pc", bus.o_Pc, 32'h8);
      chk("stall_instr", bus.o_Instruction, mem[2]);
      chk("stall_addr", bus.o_Addr, 32'h8);
      chk("stall_count", bus.o_Fetch_Count, 32'd13);
    end
    tick();
    bus.i_Stall = 1'b0;
    push(32'hC);
    #1;
    chk("release_pc", bus.o_Pc, 32'h8);
    chk("release_addr", bus.o_Addr, 32'hC);
    tick();
    push(32'h10);
    chk("after_release_pc", bus.o_Pc, 32'hC);
    chk("after_release_count", bus.o_Fetch_Count, 32'd14);

    // Redirect plus stall while the halt word is at the output
    tick();
    bus.i_Stall    = 1'b1;
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h40;
    push(32'h40);
    #1;
    chk("halt_redir_opcode", 32'(bus.o_Opcode), 32'h3F);
    chk("halt_redir_addr", bus.o_Addr, 32'h40);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h44);
    #1;
    chk("halt_redir_pc", bus.o_Pc, 32'h40);
    chk1("halt_redir_halted", bus.o_Halted, 1'b0);
    chk1("halt_redir_valid", bus.o_Valid, 1'b1);
    chk("halt_redir_count", bus.o_Fetch_Count, 32'd16);

    // Reset mid-stall
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_stall_addr", bus.o_Addr, SENTINEL_ADDR);
    tick();
    chk1("rst_stall_valid", bus.o_Valid, 1'b0);
    chk("rst_stall_pc", bus.o_Pc, SENTINEL_ADDR);
    chk("rst_stall_count", bus.o_Fetch_Count, 32'd0);
    rst = 1'b0;
    bus.i_Stall = 1'b0;
    push(32'h0);
    #1;
    chk("rst_stall_release_addr", bus.o_Addr, 32'h0);
    tick();
    push(32'h4);
    tick();
    push(32'h8);

    // Reset mid-run
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    chk1("rst_run_valid", bus.o_Valid, 1'b0);
    chk("rst_run_pc", bus.o_Pc, SENTINEL_ADDR);
    chk("rst_run_count", bus.o_Fetch_Count, 32'd0);
    rst = 1'b0;
    push(32'h0);
    tick();
    chk("rst_run_first_pc", bus.o_Pc, 32'h0);

    // Out-of-range redirect target
    bus.i_Redirect = 1'b1;
    bus.i_Target   = 32'h200;
`ifdef IFU_BOUNDS_CHECK_EN
    #1;
    chk("oob_addr", bus.o_Addr, SENTINEL_ADDR);
    tick();
    bus.i_Redirect = 1'b0;
    chk1("oob_fault", bus.o_Fault, 1'b1);
    chk1("oob_halted", bus.o_Halted, 1'b1);
    chk1("oob_valid", bus.o_Valid, 1'b0);
`else
    push(32'h200);
    #1;
    chk("oob_addr", bus.o_Addr, 32'h200);
    tick();
    bus.i_Redirect = 1'b0;
    push(32'h204);
    chk1("oob_fault", bus.o_Fault, 1'b0);
    chk("oob_pc", bus.o_Pc, 32'h200);
    chk1("oob_valid", bus.o_Valid, 1'b1);
`endif
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
